// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a registered borrow.
// Define SERIAL_SUBTRACTOR_ADD_MODE_EN to add an op input selecting a + b.
module serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
   input  logic             op,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             op_q, op_d;
   logic             op_in;

   logic             ai, bi, bit_d, br_next, ovf_bit;
   logic [WIDTH-1:0] diff_sh;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
   assign op_in = op;
`else
   assign op_in = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         op_q    <= op_d;
      end
   end

   // One full-subtractor (or full-adder) cell on the current LSBs
   always_comb begin
      ai      = a_q[0];
      bi      = b_q[0];
      bit_d   = ai ^ bi ^ br_q;
      br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
      ovf_bit = (ai ^ bi) & (ai ^ bit_d);
      if (op_q) begin
         br_next = (ai & bi) | (ai & br_q) | (bi & br_q);
         ovf_bit = ~(ai ^ bi) & (ai ^ bit_d);
      end
      diff_sh = {bit_d, diff_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      op_d    = op_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               op_d    = op_in;
               br_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d    = {1'b0, a_q[WIDTH-1:1]};
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            diff_d = diff_sh;
            br_d   = br_next;
            cnt_d  = cnt_q + CW'(1);
            // At the MSB the shifted-in bit completes the result
            if (cnt_q == LAST) begin
               state_d = DONE;
               bout_d  = br_next;
               ovf_d   = ovf_bit;
               zero_d  = ~|diff_sh;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor (WIDTH=8) against an arithmetic
// model; covers latency, corners, back-to-back, mid-run start and reset.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         op;
   logic         busy, done, bout, ovf, zero;
   logic [W-1:0] diff;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      .op      (op),
`endif
      .busy    (busy),
      .done    (done),
      .diff    (diff),
      .bout    (bout),
      .ovf     (ovf),
      .zero    (zero)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {diff, bout, ovf, zero}
   function automatic logic [W+2:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic o);
      int ua, ub, sa, sb, ur, sr;
      logic [W-1:0] r;
      ua = int'(x);
      ub = int'(y);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      if (o) begin
         ur = ua + ub;
         sr = sa + sb;
         r  = W'(ur & 255);
         return {r, ur > 255, (sr > 127) || (sr < -128), r == 0};
      end
      ur = ua - ub;
      sr = sa - sb;
      r  = W'(ur & 255);
      return {r, ua < ub, (sr > 127) || (sr < -128), r == 0};
   endfunction

   task automatic check_result(input string tag, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic o);
      logic [W+2:0] e;
      e = model(x, y, o);
      check({tag, ".diff"}, diff, e[W+2:3]);
      check({tag, ".bout"}, bout, e[2]);
      check({tag, ".ovf"}, ovf, e[1]);
      check({tag, ".zero"}, zero, e[0]);
   endtask

   // One operation; scrambles a/b after acceptance and pokes start mid-run
   task automatic do_op(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic o,
                        input bit poke);
      int n;
      @(negedge clk);
      a = x;
      b = y;
      op = o;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      op = 1'($urandom);
      n = 0;
      while (n < 20) begin
         if (poke && n == 3) start = 1'b1;
         @(posedge clk);
         n++;
         #1;
         if (poke && n == 4) start = 1'b0;
         if (done) break;
         if (!busy) break;
      end
      check({tag, ".lat"}, n, W);
      check({tag, ".busy"}, busy, 1'b0);
      check_result(tag, x, y, o);
      @(posedge clk);
      #1;
      check({tag, ".drop"}, done, 1'b0);
      check_result({tag, ".hold"}, x, y, o);
   endtask

   logic [W-1:0] qa[$], qb[$];
   logic         qo[$];

   initial begin
      logic [W-1:0] ra, rb;
      logic         ro;
      bit           seen;
      int           n;
      reset_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      op = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
      check("rst.flags", {diff, bout, ovf, zero}, '0);
      reset_n = 1'b1;

      do_op("t5m3", 8'h05, 8'h03, 1'b0, 0);
      do_op("t3m5", 8'h03, 8'h05, 1'b0, 0);
      do_op("t0m1", 8'h00, 8'h01, 1'b0, 0);
      do_op("t80m1", 8'h80, 8'h01, 1'b0, 0);
      do_op("t7Fm", 8'h7F, 8'hFF, 1'b0, 0);
      do_op("t5A", 8'h5A, 8'h5A, 1'b0, 0);
      do_op("poke", 8'h91, 8'h2C, 1'b0, 1);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      do_op("addFF", 8'hFF, 8'h01, 1'b1, 0);
      do_op("add7F", 8'h7F, 8'h01, 1'b1, 0);
`endif
      for (int i = 0; i < 12; i++) begin
         ro = 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
         ro = 1'($urandom);
`endif
         do_op("rnd", W'($urandom), W'($urandom), ro, (i % 3) == 0);
      end

      // back-to-back with start held high
      @(negedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      ro = 1'b0;
      a = ra;
      b = rb;
      op = ro;
      qa.push_back(ra);
      qb.push_back(rb);
      qo.push_back(ro);
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
         end
         check("b2b.lat", n, (k == 0) ? W : W + 1);
         check_result("b2b", qa.pop_front(), qb.pop_front(), qo.pop_front());
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
         ro = 1'($urandom);
`endif
         a = ra;
         b = rb;
         op = ro;
         qa.push_back(ra);
         qb.push_back(rb);
         qo.push_back(ro);
         if (k == 3) start = 1'b0;
      end
      @(posedge clk);
      #1;
      check("b2b.idle", {busy, done}, 2'b00);
      qa.delete();
      qb.delete();
      qo.delete();

      // reset during RUN at bit 4
      @(negedge clk);
      a = 8'h37;
      b = 8'h12;
      op = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rr.busy", busy, 1'b1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rr.clr", {busy, done, diff, bout, ovf, zero}, '0);
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) seen = 1;
      end
      check("rr.nodone", seen, 1'b0);
      do_op("t10m4", 8'd10, 8'd4, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   always @(negedge clk) begin
      if (busy && done) begin
         n_tot++;
         n_bad++;
         $display("FAIL busy_done_both: busy=%b done=%b", busy, done);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t limit=200000", $time);
      $fatal(1, "watchdog");
   end

endmodule
